// File: rtl/schedule_erase_mp_pkg.sv
// schedule_erase_mp_pkg
// Shared constants and types for the multi-plane block-erase scheduler:
// NAND erase opcodes, default wait fields, the page-command parameter
// layout, FSM state encodings and the generated-command bundle type.
package schedule_erase_mp_pkg;

  // Opcode pairs: intermediate multi-plane erase and group-final erase
  localparam logic [15:0] ERASE_MP    = 16'hD160;
  localparam logic [15:0] ERASE_FINAL = 16'hD060;

  // Default wait fields (tDBSY for intermediate planes, tBERS for group end)
  localparam logic [11:0] T_DBSY_DEFAULT = 12'h03C;
  localparam logic [11:0] T_BERS_DEFAULT = 12'h800;

  // Fixed sub-field of the page-command parameter word
  localparam logic [2:0]  PARAM_CONST = 3'h4;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // One fully formed page-level erase command
  typedef struct packed {
    logic [15:0] opcode;
    logic        last;
    logic [47:0] addr;
    logic [31:0] param;
    logic [15:0] id;
  } erase_cmd_t;

  // Parameter word layout: {16'h0, wait[11:0], 3'h4, 1'b1}
  function automatic logic [31:0] make_param(input logic [11:0] wait_v);
    return {16'h0000, wait_v, PARAM_CONST, 1'b1};
  endfunction

endpackage

// File: rtl/schedule_erase_mp_erase_cmd_gen.sv
// erase_cmd_gen
// Purely combinational page-command former. From the current block address,
// the number of blocks still to issue and the request id it derives the
// opcode, last flag, zero-extended address and parameter word.
// Ports:
//   i_cur_addr  - row address of the block being issued
//   i_remaining - blocks left including this one
//   i_id        - request id (passed through)
//   o_opcode, o_last, o_addr, o_param, o_id - formed command fields
module erase_cmd_gen
  import schedule_erase_mp_pkg::*;
#(
  parameter int          NUM_PLANES = 2,
  parameter int          ADDR_W     = 32,
  parameter int          LEN_W      = 24,
  parameter int          BLK_SHIFT  = 11,
  parameter logic [11:0] T_DBSY     = T_DBSY_DEFAULT,
  parameter logic [11:0] T_BERS     = T_BERS_DEFAULT
) (
  input  logic [ADDR_W-1:0] i_cur_addr,
  input  logic [LEN_W-1:0]  i_remaining,
  input  logic [15:0]       i_id,
  output logic [15:0]       o_opcode,
  output logic              o_last,
  output logic [47:0]       o_addr,
  output logic [31:0]       o_param,
  output logic [15:0]       o_id
);

  logic w_plane_last;
  logic w_last;
  logic w_final;

  // A single-plane LUN has no plane field, so every command closes its group
  generate
    if (NUM_PLANES == 1) begin : g_single
      assign w_plane_last = 1'b1;
    end else begin : g_multi
      localparam int PLANE_BITS = $clog2(NUM_PLANES);
      assign w_plane_last =
        (i_cur_addr[BLK_SHIFT +: PLANE_BITS] == PLANE_BITS'(NUM_PLANES - 1));
    end
  endgenerate

  // Form the command; the group closes on the top plane or the request's final block
  always_comb begin
    w_last  = (i_remaining == LEN_W'(1'b1));
    w_final = w_last | w_plane_last;
    o_last  = w_last;
    o_addr  = 48'(i_cur_addr);
    o_id    = i_id;
    if (w_final) begin
      o_opcode = ERASE_FINAL;
      o_param  = make_param(T_BERS);
    end else begin
      o_opcode = ERASE_MP;
      o_param  = make_param(T_DBSY);
    end
  end

endmodule

// File: rtl/schedule_erase_mp.sv
// schedule_erase_mp
// Multi-plane block-erase scheduler. Accepts {id, start row, block count},
// emits one page-level erase command per block (grouped into multi-plane
// sequences that never cross the top plane) and pulses o_done at the end.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   o_cmd_ready         - request accept (high in IDLE)
//   i_cmd_valid, i_ecmd_id, i_eaddr, i_elen - erase request
//   i_page_cmd_ready    - downstream ready
//   o_page_cmd_valid, o_page_cmd, o_page_cmd_last, o_page_cmd_id,
//   o_page_addr, o_page_cmd_param - registered page command
//   o_busy              - request in progress
//   o_done, o_done_id   - one-cycle completion pulse and its id
module schedule_erase_mp
  import schedule_erase_mp_pkg::*;
#(
  parameter int          NUM_PLANES = 2,
  parameter int          ADDR_W     = 32,
  parameter int          LEN_W      = 24,
  parameter int          BLK_SHIFT  = 11,
  parameter logic [11:0] T_DBSY     = T_DBSY_DEFAULT,
  parameter logic [11:0] T_BERS     = T_BERS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_cmd_ready,
  input  logic              i_cmd_valid,
  input  logic [15:0]       i_ecmd_id,
  input  logic [ADDR_W-1:0] i_eaddr,
  input  logic [LEN_W-1:0]  i_elen,
  input  logic              i_page_cmd_ready,
  output logic              o_page_cmd_valid,
  output logic [15:0]       o_page_cmd,
  output logic              o_page_cmd_last,
  output logic [15:0]       o_page_cmd_id,
  output logic [47:0]       o_page_addr,
  output logic [31:0]       o_page_cmd_param,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_done_id
);

  localparam logic [ADDR_W-1:0] BLK_STRIDE = ADDR_W'(64'd1 << BLK_SHIFT);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [15:0]       r_id;

  logic [ADDR_W-1:0] w_gen_addr;
  logic [LEN_W-1:0]  w_gen_rem;
  logic [15:0]       w_gen_id;
  logic              w_hs;
  erase_cmd_t        w_gen;

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign w_hs        = o_page_cmd_valid & i_page_cmd_ready;

  // Select what the former sees: the new request in IDLE, the post-increment
  // block in ISSUE, so the next command can be registered without a bubble
  always_comb begin
    w_gen_addr = r_cur_addr;
    w_gen_rem  = r_remaining;
    w_gen_id   = r_id;
    case (r_state)
      ST_IDLE: begin
        w_gen_addr = i_eaddr;
        w_gen_rem  = i_elen;
        w_gen_id   = i_ecmd_id;
      end
      ST_ISSUE: begin
        w_gen_addr = r_cur_addr + BLK_STRIDE;
        w_gen_rem  = r_remaining - LEN_W'(1'b1);
        w_gen_id   = r_id;
      end
      default: begin
        w_gen_addr = r_cur_addr;
        w_gen_rem  = r_remaining;
        w_gen_id   = r_id;
      end
    endcase
  end

  erase_cmd_gen #(
    .NUM_PLANES (NUM_PLANES),
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .BLK_SHIFT  (BLK_SHIFT),
    .T_DBSY     (T_DBSY),
    .T_BERS     (T_BERS)
  ) u_gen (
    .i_cur_addr  (w_gen_addr),
    .i_remaining (w_gen_rem),
    .i_id        (w_gen_id),
    .o_opcode    (w_gen.opcode),
    .o_last      (w_gen.last),
    .o_addr      (w_gen.addr),
    .o_param     (w_gen.param),
    .o_id        (w_gen.id)
  );

  // FSM, block counters and registered command/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_cur_addr       <= {ADDR_W{1'b0}};
      r_remaining      <= {LEN_W{1'b0}};
      r_id             <= 16'h0000;
      o_page_cmd_valid <= 1'b0;
      o_page_cmd       <= 16'h0000;
      o_page_cmd_last  <= 1'b0;
      o_page_cmd_id    <= 16'h0000;
      o_page_addr      <= 48'h0;
      o_page_cmd_param <= 32'h0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_done_id        <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_cmd_valid) begin
            r_id        <= i_ecmd_id;
            r_cur_addr  <= i_eaddr;
            r_remaining <= i_elen;
            o_busy      <= 1'b1;
            if (i_elen == LEN_W'(1'b0)) begin
              // Empty request completes without touching the command port
              r_state   <= ST_DONE;
              o_done    <= 1'b1;
              o_done_id <= i_ecmd_id;
            end else begin
              r_state          <= ST_ISSUE;
              o_page_cmd_valid <= 1'b1;
              o_page_cmd       <= w_gen.opcode;
              o_page_cmd_last  <= w_gen.last;
              o_page_cmd_id    <= w_gen.id;
              o_page_addr      <= w_gen.addr;
              o_page_cmd_param <= w_gen.param;
            end
          end
        end
        ST_ISSUE: begin
          if (w_hs) begin
            if (r_remaining == LEN_W'(1'b1)) begin
              r_state          <= ST_DONE;
              o_page_cmd_valid <= 1'b0;
              o_page_cmd_last  <= 1'b0;
              o_done           <= 1'b1;
              o_done_id        <= r_id;
            end else begin
              r_cur_addr       <= w_gen_addr;
              r_remaining      <= w_gen_rem;
              o_page_cmd       <= w_gen.opcode;
              o_page_cmd_last  <= w_gen.last;
              o_page_cmd_id    <= w_gen.id;
              o_page_addr      <= w_gen.addr;
              o_page_cmd_param <= w_gen.param;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
        default: begin
          r_state          <= ST_IDLE;
          o_busy           <= 1'b0;
          o_done           <= 1'b0;
          o_page_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_schedule_erase_mp.sv
// tb_schedule_erase_mp
// Table-driven plus randomized bench for the erase scheduler. A 4-plane
// instance runs table and random requests checked against an arithmetic
// model; a 1-plane instance covers address wrap; a hand sequence covers
// reset in the middle of a request.
module tb_schedule_erase_mp;

  localparam logic [11:0] TB_DBSY = 12'h03C;
  localparam logic [11:0] TB_BERS = 12'h800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-plane instance
  logic        cmd_ready, cmd_valid, pready;
  logic [15:0] ecmd_id;
  logic [31:0] eaddr;
  logic [23:0] elen;
  logic        pvalid, plast, busy, done;
  logic [15:0] pcmd, pid, done_id;
  logic [47:0] paddr;
  logic [31:0] pparam;

  // 1-plane instance
  logic        n1_cmd_ready, n1_cmd_valid, n1_pready;
  logic [15:0] n1_ecmd_id;
  logic [31:0] n1_eaddr;
  logic [23:0] n1_elen;
  logic        n1_pvalid, n1_plast, n1_busy, n1_done;
  logic [15:0] n1_pcmd, n1_pid, n1_done_id;
  logic [47:0] n1_paddr;
  logic [31:0] n1_pparam;

  schedule_erase_mp #(.NUM_PLANES(4), .ADDR_W(32), .LEN_W(24), .BLK_SHIFT(11),
                      .T_DBSY(TB_DBSY), .T_BERS(TB_BERS)) u_dut4 (
    .clk(clk), .rst(rst), .o_cmd_ready(cmd_ready), .i_cmd_valid(cmd_valid),
    .i_ecmd_id(ecmd_id), .i_eaddr(eaddr), .i_elen(elen),
    .i_page_cmd_ready(pready), .o_page_cmd_valid(pvalid), .o_page_cmd(pcmd),
    .o_page_cmd_last(plast), .o_page_cmd_id(pid), .o_page_addr(paddr),
    .o_page_cmd_param(pparam), .o_busy(busy), .o_done(done), .o_done_id(done_id)
  );

  schedule_erase_mp #(.NUM_PLANES(1), .ADDR_W(32), .LEN_W(24), .BLK_SHIFT(11),
                      .T_DBSY(TB_DBSY), .T_BERS(TB_BERS)) u_dut1 (
    .clk(clk), .rst(rst), .o_cmd_ready(n1_cmd_ready), .i_cmd_valid(n1_cmd_valid),
    .i_ecmd_id(n1_ecmd_id), .i_eaddr(n1_eaddr), .i_elen(n1_elen),
    .i_page_cmd_ready(n1_pready), .o_page_cmd_valid(n1_pvalid), .o_page_cmd(n1_pcmd),
    .o_page_cmd_last(n1_plast), .o_page_cmd_id(n1_pid), .o_page_addr(n1_paddr),
    .o_page_cmd_param(n1_pparam), .o_busy(n1_busy), .o_done(n1_done),
    .o_done_id(n1_done_id)
  );

  typedef struct packed {
    logic [15:0]       id;
    logic [31:0]       addr;
    logic [23:0]       len;
    logic              mode;      // 0: ready held high, 1: random ready
    logic [7:0][15:0]  exp_ops;
    logic [7:0]        exp_last;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [15:0] obs_op   [16];
  logic        obs_last [16];
  int          obs_n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0][15:0] ops5(input logic [15:0] a, b, c, d, e);
    return {16'h0, 16'h0, 16'h0, e, d, c, b, a};
  endfunction

  // Expected command i of a request: plain address arithmetic and plane rule
  function automatic logic [63:0] model_cmd(input logic [31:0] base, input int i,
                                            input int len, output logic [47:0] ex_addr,
                                            output logic [31:0] ex_param);
    logic [31:0] a;
    int          plane;
    logic        fin;
    a        = base + 32'(i) * 32'h800;
    plane    = int'((a >> 11) % 32'd4);
    fin      = (plane == 3) || (i == len - 1);
    ex_addr  = {16'h0, a};
    ex_param = {16'h0, (fin ? TB_BERS : TB_DBSY), 3'h4, 1'b1};
    return {47'h0, (i == len - 1), (fin ? 16'hD060 : 16'hD160)};
  endfunction

  task automatic run_req(input vec_t v);
    int          k, idx, cyc, len;
    logic        have_snap;
    logic [48:0] snap_f;
    logic [47:0] snap_a;
    logic [63:0] m;
    logic [47:0] ex_a;
    logic [31:0] ex_p;
    len = int'(v.len);
    obs_n = 0;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("wait_ready_timeout", 64'(k), 64'd0);
    cmd_valid = 1'b1;
    ecmd_id   = v.id;
    eaddr     = v.addr;
    elen      = v.len;
    pready    = v.mode ? 1'($urandom % 2) : 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ecmd_id   = 16'hFFFF;   // junk outside IDLE must be ignored
    idx = 0;
    cyc = 0;
    have_snap = 1'b0;
    while (idx < len && cyc < 200) begin
      if (pvalid) begin
        if (have_snap) begin
          chk("stable_fields", {pcmd, plast, pparam}, snap_f);
          chk("stable_addr", 64'(paddr), 64'(snap_a));
        end
        m = model_cmd(v.addr, idx, len, ex_a, ex_p);
        chk("opcode", 64'(pcmd), 64'(m[15:0]));
        chk("last", 64'(plast), 64'(m[16]));
        chk("addr", 64'(paddr), 64'(ex_a));
        chk("param", 64'(pparam), 64'(ex_p));
        chk("cmd_id", 64'(pid), 64'(v.id));
        pready = v.mode ? 1'($urandom % 2) : 1'b1;
        if (pready) begin
          obs_op[idx]   = pcmd;
          obs_last[idx] = plast;
          obs_n++;
          idx++;
          have_snap = 1'b0;
        end else begin
          snap_f    = {pcmd, plast, pparam};
          snap_a    = paddr;
          have_snap = 1'b1;
        end
      end else begin
        chk("valid_low_mid_request", 64'(pvalid), 64'd1);
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) chk("issue_timeout", 64'(idx), 64'(len));
    if (!v.mode) chk("consecutive_cycles", 64'(cyc), 64'(len));
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_id", 64'(done_id), 64'(v.id));
    chk("valid_after_last", 64'(pvalid), 64'd0);
    chk("busy_in_done", 64'(busy), 64'd1);
    chk("ready_in_done", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("ready_after_done", 64'(cmd_ready), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  vec_t vecs [4];
  vec_t rv;

  initial begin
    cmd_valid = 1'b0; ecmd_id = 16'h0; eaddr = 32'h0; elen = 24'h0; pready = 1'b1;
    n1_cmd_valid = 1'b0; n1_ecmd_id = 16'h0; n1_eaddr = 32'h0; n1_elen = 24'h0;
    n1_pready = 1'b1;

    vecs[0] = '{id: 16'h0001, addr: 32'h800, len: 24'd5, mode: 1'b0,
                exp_ops: ops5(16'hD160, 16'hD160, 16'hD060, 16'hD160, 16'hD060),
                exp_last: 8'b0001_0000};
    vecs[1] = '{id: 16'h0002, addr: 32'h0, len: 24'd4, mode: 1'b0,
                exp_ops: ops5(16'hD160, 16'hD160, 16'hD160, 16'hD060, 16'h0),
                exp_last: 8'b0000_1000};
    vecs[2] = '{id: 16'h0003, addr: 32'h800, len: 24'd5, mode: 1'b1,
                exp_ops: ops5(16'hD160, 16'hD160, 16'hD060, 16'hD160, 16'hD060),
                exp_last: 8'b0001_0000};
    vecs[3] = '{id: 16'h00AB, addr: 32'h1234_5000, len: 24'd0, mode: 1'b0,
                exp_ops: ops5(16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
                exp_last: 8'b0000_0000};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_valid", 64'(pvalid), 64'd0);
    chk("rst_busy_done_last", {busy, done, plast}, 64'd0);
    chk("rst_payload", {pcmd, pid, done_id}, 64'd0);
    chk("rst_addr_param", {paddr, 16'h0} ^ 64'(pparam), 64'd0);

    // Table-driven requests
    for (int t = 0; t < 4; t++) begin
      run_req(vecs[t]);
      chk("tbl_count", 64'(obs_n), 64'(vecs[t].len));
      for (int i = 0; i < int'(vecs[t].len); i++) begin
        chk("tbl_opcode", 64'(obs_op[i]), 64'(vecs[t].exp_ops[i]));
        chk("tbl_last", 64'(obs_last[i]), 64'(vecs[t].exp_last[i]));
      end
    end

    // Randomized requests against the model
    for (int r = 0; r < 25; r++) begin
      rv.id   = 16'($urandom);
      rv.addr = (r % 4 == 0) ? (32'hFFFF_E000 + 32'($urandom_range(0, 7)) * 32'h800)
                             : $urandom;
      rv.len  = 24'($urandom_range(0, 9));
      rv.mode = 1'($urandom % 2);
      rv.exp_ops = '0;
      rv.exp_last = 8'h00;
      run_req(rv);
      chk("rnd_count", 64'(obs_n), 64'(rv.len));
    end

    // Single-plane instance: every command is final, address wraps
    @(negedge clk);
    n1_cmd_valid = 1'b1; n1_ecmd_id = 16'h0077; n1_eaddr = 32'hFFFF_F800;
    n1_elen = 24'd2; n1_pready = 1'b1;
    @(negedge clk);
    n1_cmd_valid = 1'b0;
    chk("np1_valid0", 64'(n1_pvalid), 64'd1);
    chk("np1_op0", 64'(n1_pcmd), 64'hD060);
    chk("np1_addr0", 64'(n1_paddr), 64'h0000_FFFF_F800);
    chk("np1_param0", 64'(n1_pparam), 64'h0000_8009);
    chk("np1_last0", 64'(n1_plast), 64'd0);
    @(negedge clk);
    chk("np1_op1", 64'(n1_pcmd), 64'hD060);
    chk("np1_addr1_wrap", 64'(n1_paddr), 64'h0);
    chk("np1_param1", 64'(n1_pparam), 64'h0000_8009);
    chk("np1_last1", 64'(n1_plast), 64'd1);
    @(negedge clk);
    chk("np1_done", {n1_done, n1_done_id, n1_pvalid}, {47'h0, 1'b1, 16'h0077, 1'b0});

    // Reset in the middle of a len-8 request
    @(negedge clk);
    cmd_valid = 1'b1; ecmd_id = 16'h0055; eaddr = 32'h0; elen = 24'd8; pready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_third_addr", 64'(paddr), 64'h1000);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(pvalid), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_busy_done_last", {busy, done, plast}, 64'd0);
    chk("mid_rst_payload", {pcmd, pid, done_id}, 64'd0);
    chk("mid_rst_addr", 64'(paddr), 64'd0);
    chk("mid_rst_param", 64'(pparam), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", {done, pvalid, busy}, 64'd0);
    end
    run_req(vecs[1]);
    chk("post_rst_count", 64'(obs_n), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/schedule_erase_mp.md
# schedule_erase_mp

Parametrised multi-plane block-erase scheduler for the NAND flash controller. It accepts an erase request (command id, starting row address, block count) and splits it into a stream of page-level erase commands. Consecutive blocks are grouped into multi-plane erase sequences of up to NUM_PLANES blocks. It sits between the command dispatcher and the page-command arbiter, next to the read/program schedulers, and signals request completion.

## Interface
- NUM_PLANES, 2, planes per LUN; legal values 1, 2, 4. PLANE_BITS = clog2(NUM_PLANES); PLANE_BITS = 0 when NUM_PLANES = 1.
- ADDR_W, 32, row address width.
- LEN_W, 24, block-count width.
- BLK_SHIFT, 11, bit position of the block LSB in the row address. Block stride is 1<<BLK_SHIFT. Plane index is addr[BLK_SHIFT +: PLANE_BITS].
- T_DBSY, `tDBSY (12 bit), wait field for intermediate multi-plane commands.
- T_BERS, 12'h800, wait field for group-final erase commands.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- o_cmd_ready  out  1  request accept
- i_cmd_valid  in  1  request valid
- i_ecmd_id  in  16  request id
- i_eaddr  in  ADDR_W  starting row address
- i_elen  in  LEN_W  number of blocks
- i_page_cmd_ready  in  1  downstream ready
- o_page_cmd_valid  out  1  page command valid
- o_page_cmd  out  16  opcode pair
- o_page_cmd_last  out  1  final command of request
- o_page_cmd_id  out  16  request id
- o_page_addr  out  48  row address, zero-extended
- o_page_cmd_param  out  32  {16'h0, wait[11:0], 3'h4, 1'b1}
- o_busy  out  1  request in progress
- o_done  out  1  one-cycle completion pulse
- o_done_id  out  16  id of completed request, valid with o_done

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid, latch id, addr and len.
  - len = 0: go to DONE; no page command is issued.
  - len > 0: go to ISSUE.
- ISSUE:
  - Present one command per block, at address cur_addr.
  - Plane p = cur_addr[BLK_SHIFT +: PLANE_BITS].
  - The command is group-final if p == NUM_PLANES-1, or remaining == 1, or NUM_PLANES == 1.
  - Group-final: opcode 16'hD060, wait = T_BERS. Otherwise: opcode 16'hD160, wait = T_DBSY.
  - o_page_cmd_last = (remaining == 1).
  - On handshake (valid & ready):
    - cur_addr += 1<<BLK_SHIFT, modulo 2^ADDR_W (wrap silently).
    - remaining -= 1.
    - After the last block, go to DONE.
- DONE: o_done = 1 and o_done_id = id for one cycle, then return to IDLE.
- o_busy = (state != IDLE).
- A group never crosses a plane-(NUM_PLANES-1) boundary. A start on plane p > 0 produces a short first group.

## Timing
- Reset values:
  - state = IDLE; o_cmd_ready = 1; o_page_cmd_valid = 0; o_page_cmd_last = 0; o_busy = 0; o_done = 0.
  - o_page_cmd, o_page_cmd_id, o_page_addr, o_page_cmd_param, o_done_id all 0.
- All outputs are registered. o_cmd_ready is the exception: it is decoded directly from state.
- Request accepted at cycle N → first o_page_cmd_valid at N+1.
- Valid/ready rule: once valid is asserted, valid and every payload field stay stable until the handshake. Valid never drops without a handshake.
- Throughput: one command per cycle while i_page_cmd_ready = 1. There is no inter-command bubble, so next-command fields are computed combinationally from the post-increment values.
- Last handshake at cycle M → o_done at M+1 → o_cmd_ready at M+2.
- len = 0 accepted at N → o_done at N+1, with no page command.
- Reset mid-request: everything returns to reset values immediately. The request is abandoned and no o_done is produced.
- i_cmd_valid outside IDLE is ignored.

## Structure
- nfc_param.vh holds the shared constants: opcodes ERASE_MP (16'hD160) and ERASE_FINAL (16'hD060), `tDBSY, the default T_BERS, and the param-field constant 3'h4.
- One sub-module, erase_cmd_gen: purely combinational. It takes cur_addr, remaining and id, and produces opcode, last, addr and param. The FSM, counters and output registers stay in schedule_erase_mp.

## Test plan
All scenarios use NUM_PLANES = 4 and BLK_SHIFT = 11 unless stated.
- addr 0x800 (plane 1), len 5, ready held at 1:
  - Opcodes D160, D160, D060, D160, D060.
  - Addresses 0x800, 0x1000, 0x1800, 0x2000, 0x2800.
  - last only on the 5th command; o_done one cycle after it; 5 commands in 5 consecutive cycles.
- addr 0x0, len 4: opcodes D160, D160, D160, D060; last on the 4th.
- Same as the first scenario with ready toggling 1-0-1 randomly: payload is stable while valid & !ready; command sequence is unchanged.
- len 0, id 0x00AB: no o_page_cmd_valid; o_done with o_done_id = 0x00AB one cycle after accept.
- NUM_PLANES = 1, addr 0xFFFF_F800, len 2:
  - Two D060 commands, each with param wait = 0x800.
  - Second address 0x0 (wrap).
- rst asserted after the 2nd handshake of a len-8 request: all outputs return to reset values the same cycle; no o_done; a new request is accepted afterwards.
